// File: rtl/my_mux_pkg.sv
// Shared definitions for the registered N-way arbitrated multiplexer.
//   arb_mode_t  : arbitration mode carried on the mode port
//   DEF_WIDTH   : default data bits per way
//   DEF_WAYS    : default number of ways
//   wrap_inc    : index increment with wrap at an arbitrary (non power-of-2) limit
package my_mux_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_WAYS  = 4;

  // Next index after idx, returning to 0 after ways-1 so the result never reaches ways.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned ways);
    if (idx + 32'd1 >= ways) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/my_rr_arbiter.sv
// Combinational arbiter: fixed priority (lowest index) or round-robin search
// starting at ptr and wrapping WAYS-1 -> 0.
//   in_valid  [WAYS]   : per-way requests
//   ptr       [SEL_W]  : round-robin start index, always < WAYS
//   mode      [1]      : ARB_FIXED / ARB_RR
//   grant     [WAYS]   : one-hot grant, zero when nothing requests
//   grant_idx [SEL_W]  : binary index of the granted way
//   grant_any [1]      : some way is granted
module my_rr_arbiter
  import my_mux_pkg::*;
#(
  parameter  int WAYS  = DEF_WAYS,
  localparam int SEL_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  in_valid,
  input  logic [SEL_W-1:0] ptr,
  input  arb_mode_t        mode,
  output logic [WAYS-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_any
);

  int               cand_s;
  logic [SEL_W-1:0] cand_idx_s;
  logic             found_s;

  // Walk candidates in priority order; the first requesting one wins.
  always_comb begin
    grant      = '0;
    grant_idx  = '0;
    found_s    = 1'b0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int k = 0; k < WAYS; k++) begin
      // ptr + k is below 2*WAYS, so a single subtraction performs the wrap.
      if (mode == ARB_RR && (int'(ptr) + k) >= WAYS) begin
        cand_s = int'(ptr) + k - WAYS;
      end else if (mode == ARB_RR) begin
        cand_s = int'(ptr) + k;
      end else begin
        cand_s = k;
      end
      cand_idx_s = SEL_W'(cand_s);
      if (!found_s && in_valid[cand_idx_s]) begin
        grant[cand_idx_s] = 1'b1;
        grant_idx         = cand_idx_s;
        found_s           = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign grant_any = found_s;

endmodule

// File: rtl/my_mux_n_way_arb.sv
// Registered N-way multiplexer with valid/ready on every way, a one-entry
// output register and source tagging of the delivered word.
//   clk       [1]           : rising-edge clock
//   rst_n     [1]           : synchronous active-low reset
//   mode      [1]           : ARB_FIXED (lowest index wins) / ARB_RR
//   in_data   [WAYS*WIDTH]  : way i at [i*WIDTH +: WIDTH]
//   in_valid  [WAYS]        : per-way request
//   in_ready  [WAYS]        : per-way accept, at most one bit high
//   out_data  [WIDTH]       : registered selected data
//   out_sel   [SEL_W]       : index of the way that supplied out_data
//   out_valid [1]           : output register holds a word
//   out_ready [1]           : downstream accept
module my_mux_n_way_arb
  import my_mux_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int WAYS  = DEF_WAYS,
  localparam int SEL_W = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  arb_mode_t         mode,
  input  logic [WAYS*WIDTH-1:0] in_data,
  input  logic [WAYS-1:0]   in_valid,
  output logic [WAYS-1:0]   in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] ptr_next_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SEL_W-1:0] out_sel_r;
  logic [WAYS-1:0]  grant_s;
  logic [SEL_W-1:0] grant_idx_s;
  logic             grant_any_s;
  logic             can_load_s;
  logic             accept_s;
  logic [WIDTH-1:0] sel_data_s;

  my_rr_arbiter #(
    .WAYS (WAYS)
  ) u_arb (
    .in_valid  (in_valid),
    .ptr       (ptr_r),
    .mode      (mode),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  // The register may load when empty or when it is draining on this edge.
  assign can_load_s = ~out_valid_r | out_ready;
  // Qualifying with rst_n keeps producers from seeing an accept that the reset edge discards.
  assign in_ready   = grant_s & {WAYS{can_load_s & rst_n}};
  assign accept_s   = grant_any_s & can_load_s;
  assign ptr_next_s = SEL_W'(wrap_inc(32'(grant_idx_s), 32'(WAYS)));

  // AND-OR data select over the one-hot grant.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < WAYS; i++) begin
      sel_data_s = sel_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
      ptr_r       <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= sel_data_s;
      out_sel_r   <= grant_idx_s;
      // Fixed mode leaves ptr untouched so switching back resumes the rotation.
      if (mode == ARB_RR) begin
        ptr_r <= ptr_next_s;
      end else begin
        ptr_r <= ptr_r;
      end
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_my_mux_n_way_arb.sv
// Directed bench for my_mux_n_way_arb: a 4-way/16-bit and a 3-way/8-bit
// instance run side by side against a behavioural model, with literal
// expectations at the key points of each scenario.
module tb_my_mux_n_way_arb;
  import my_mux_pkg::*;

  logic       clk;
  logic       rst_n;
  arb_mode_t  mode;
  logic       out_ready;

  logic [63:0] in_data4;
  logic [3:0]  in_valid4;
  logic [3:0]  in_ready4;
  logic [15:0] out_data4;
  logic [1:0]  out_sel4;
  logic        out_valid4;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        out_valid3;

  int nvec;
  int nmis;
  bit chk_en;

  // model state per instance
  bit m4_v; int m4_d; int m4_s; int m4_p;
  bit m3_v; int m3_d; int m3_s; int m3_p;

  my_mux_n_way_arb #(.WIDTH(16), .WAYS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .out_data(out_data4), .out_sel(out_sel4),
    .out_valid(out_valid4), .out_ready(out_ready)
  );

  my_mux_n_way_arb #(.WIDTH(8), .WAYS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_sel(out_sel3),
    .out_valid(out_valid3), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner index from the arbitration rules, -1 if nothing requests.
  function automatic int pick(input logic [3:0] v, input int ways, input bit rr, input int p);
    for (int k = 0; k < ways; k++) begin
      int j;
      j = rr ? (p + k) % ways : k;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(input logic [3:0] v, input int ways, input bit mv, input int mp);
    int w;
    w = pick(v, ways, mode == ARB_RR, mp);
    if (!rst_n) return 4'b0000;
    if ((!mv || out_ready) && w >= 0) return 4'(1 << w);
    return 4'b0000;
  endfunction

  task automatic model_step(input int ways, input int width, input logic [3:0] v,
                            input logic [63:0] data, inout bit mv, inout int md,
                            inout int ms, inout int mp);
    int w;
    if (!rst_n) begin
      mv = 1'b0; md = 0; ms = 0; mp = 0;
    end else begin
      w = pick(v, ways, mode == ARB_RR, mp);
      if ((!mv || out_ready) && w >= 0) begin
        mv = 1'b1;
        md = int'((data >> (w * width)) & ((64'd1 << width) - 64'd1));
        ms = w;
        if (mode == ARB_RR) mp = (w + 1) % ways;
      end else if (out_ready) begin
        mv = 1'b0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(4, 16, in_valid4, in_data4, m4_v, m4_d, m4_s, m4_p);
    model_step(3, 8, {1'b0, in_valid3}, 64'(in_data3), m3_v, m3_d, m3_s, m3_p);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid4", 64'(out_valid4), 64'(m4_v));
      chk("out_data4",  64'(out_data4),  64'(m4_d));
      chk("out_sel4",   64'(out_sel4),   64'(m4_s));
      chk("in_ready4",  64'(in_ready4),  64'(exp_ready(in_valid4, 4, m4_v, m4_p)));
      chk("ptr4",       64'(dut4.ptr_r), 64'(m4_p));
      chk("out_valid3", 64'(out_valid3), 64'(m3_v));
      chk("out_data3",  64'(out_data3),  64'(m3_d));
      chk("out_sel3",   64'(out_sel3),   64'(m3_s));
      chk("in_ready3",  64'(in_ready3),  64'(exp_ready({1'b0, in_valid3}, 3, m3_v, m3_p)));
      chk("ptr3",       64'(dut3.ptr_r), 64'(m3_p));
      chk("ptr3_range", 64'(dut3.ptr_r < 2'd3), 64'd1);
    end
  end

  logic [3:0] tbl_v [6];
  logic       tbl_r [6];

  initial begin
    nvec = 0; nmis = 0; chk_en = 1'b0;
    m4_v = 1'b0; m4_d = 0; m4_s = 0; m4_p = 0;
    m3_v = 1'b0; m3_d = 0; m3_s = 0; m3_p = 0;
    tbl_v[0] = 4'b0110; tbl_r[0] = 1'b1;
    tbl_v[1] = 4'b1001; tbl_r[1] = 1'b0;
    tbl_v[2] = 4'b0000; tbl_r[2] = 1'b1;
    tbl_v[3] = 4'b0100; tbl_r[3] = 1'b1;
    tbl_v[4] = 4'b1111; tbl_r[4] = 1'b0;
    tbl_v[5] = 4'b0011; tbl_r[5] = 1'b1;

    rst_n = 1'b0; mode = ARB_RR; out_ready = 1'b1;
    in_valid4 = 4'hF; in_valid3 = 3'b111;
    in_data4 = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    in_data3 = {8'h32, 8'h31, 8'h30};

    // reset held 3 cycles with every way requesting
    @(posedge clk);
    chk_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_in_ready4", 64'(in_ready4), 64'h0);
      chk("rst_out_valid4", 64'(out_valid4), 64'h0);
      chk("rst_out_data4", 64'(out_data4), 64'h0);
      chk("rst_out_sel4", 64'(out_sel4), 64'h0);
      chk("rst_in_ready3", 64'(in_ready3), 64'h0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant4", 64'(in_ready4), 64'h1);
    chk("first_grant3", 64'(in_ready3), 64'h1);

    // round-robin rotation, 4-way and non-power-of-2 3-way
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_data4", 64'(out_data4), 64'(16'hA000 + 16'(k % 4)));
      chk("rr_sel3", 64'(out_sel3), 64'(k % 3));
    end

    // backpressure for 5 cycles, then release
    @(posedge clk); #1 out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready4", 64'(in_ready4), 64'h0);
      chk("bp_out_valid4", 64'(out_valid4), 64'h1);
      chk("bp_out_data4", 64'(out_data4), 64'hA000);
      chk("bp_out_sel4", 64'(out_sel4), 64'h0);
      chk("bp_out_sel3", 64'(out_sel3), 64'h2);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready4", 64'(in_ready4), 64'h2);
    chk("bp_release_ready3", 64'(in_ready3), 64'h1);
    @(negedge clk);
    chk("bp_no_bubble_valid4", 64'(out_valid4), 64'h1);
    chk("bp_no_bubble_data4", 64'(out_data4), 64'hA001);
    chk("bp_no_bubble_sel3", 64'(out_sel3), 64'h0);

    // fixed priority with ways 1 and 3 requesting
    @(posedge clk); #1 mode = ARB_FIXED; in_valid4 = 4'b1010; in_valid3 = 3'b110;
    @(posedge clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("fix_sel4", 64'(out_sel4), 64'h1);
      chk("fix_data4", 64'(out_data4), 64'hA001);
      chk("fix_ready4", 64'(in_ready4), 64'h2);
      chk("fix_sel3", 64'(out_sel3), 64'h1);
      chk("fix_ready3", 64'(in_ready3), 64'h2);
    end

    // mixed request patterns and backpressure in round-robin mode
    @(posedge clk); #1 mode = ARB_RR;
    for (int t = 0; t < 6; t++) begin
      in_valid4 = tbl_v[t];
      in_valid3 = tbl_v[t][2:0];
      out_ready = tbl_r[t];
      @(posedge clk); #1;
    end

    // reset while a word is held
    in_valid4 = 4'hF; in_valid3 = 3'b111; out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_pre_valid4", 64'(out_valid4), 64'h1);
    chk("mid_ready_forced4", 64'(in_ready4), 64'h0);
    @(negedge clk);
    chk("mid_valid4", 64'(out_valid4), 64'h0);
    chk("mid_data4", 64'(out_data4), 64'h0);
    chk("mid_ptr4", 64'(dut4.ptr_r), 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_release_ready4", 64'(in_ready4), 64'h1);
    @(negedge clk);
    chk("mid_first_data4", 64'(out_data4), 64'hA000);
    chk("mid_first_sel4", 64'(out_sel4), 64'h0);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/my_mux_n_way_arb.md
# my_mux_n_way_arb

Parametrised, registered N-way multiplexer with per-input valid/ready handshake and selectable fixed-priority or round-robin arbitration. It is the next generation of the team's combinational 16-bit 4-way mux and generalises width and way count. It adds flow control, a one-entry output register, and source tagging. It sits between several producers sharing one downstream bus, for example register-file read ports or memory-mapped sources feeding the ALU/CPU datapath.

## Interface
Parameters:
- WIDTH, 16, data bits per way; must be at least 1.
- WAYS, 4, number of inputs; must be at least 2 and need not be a power of 2.
- SEL_W, derived localparam equal to $clog2(WAYS), width of the source index.

Ports:
- clk  input  1  single clock; everything is rising-edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
- mode  input  1  arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- in_data  input  WAYS*WIDTH  flattened inputs; way i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  WAYS  per-way request.
- in_ready  output  WAYS  per-way accept; at most one bit is high per cycle.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  index of the way that supplied out_data.
- out_valid  output  1  out_data/out_sel hold a word.
- out_ready  input  1  downstream accept.

## Operation
- Output register state is out_valid, out_data and out_sel. A transfer out happens on out_valid & out_ready.
- can_load = ~out_valid | out_ready, so a load in the same cycle as a drain is allowed.
- Grant is one-hot, combinational from in_valid, mode and ptr.
  - Fixed mode: lowest asserted index.
  - Round-robin mode: first asserted index at or after ptr, searching upward with wrap WAYS-1 → 0.
- in_ready = grant & {WAYS{can_load}}. in_ready does not depend on in_valid of other ways beyond the grant.
- On the rising edge with a granted valid input and can_load:
  - out_data ← in_data of the granted way.
  - out_sel ← its index.
  - out_valid ← 1.
- Otherwise, if out_ready is high, out_valid ← 0. If neither, the output holds.
- ptr (SEL_W bits, internal) updates only on an accepted input transfer, and only in round-robin mode: ptr ← granted index + 1.
  - Index WAYS-1 wraps to 0; this holds for non-power-of-2 WAYS. ptr never takes a value ≥ WAYS.
- A mode change takes effect on the next grant computation. ptr is retained in fixed mode, not reset.
- Producers must hold in_data and in_valid stable until accepted. The block does not enforce this.

## Timing
- Reset values while rst_n is low at a clock edge:
  - out_valid = 0, out_data = 0, out_sel = 0, ptr = 0.
  - in_ready is forced to all-zero during any cycle with rst_n low.
- Reset mid-transfer discards the held word. No transfer is counted on the reset edge.
- Latency is 1 cycle from input acceptance to out_valid.
- Throughput is 1 word per cycle with out_ready held high.
- Backpressure: out_valid & ~out_ready forces in_ready = 0 for all ways, and out_data/out_sel are held stable.
- Full/empty: the register holds one entry. Full with out_ready high means drain and load in the same edge, with no bubble.
- Under continuous contention in round-robin mode, every requesting way is served within WAYS accepted transfers.
- Combinational paths: in_valid, mode and out_ready drive in_ready. No path from in_data to any output exists within a cycle.

## Structure
- Package my_mux_pkg holds:
  - typedef enum logic {ARB_FIXED = 0, ARB_RR = 1} arb_mode_t, used for the mode port.
  - Default constants DEF_WIDTH = 16 and DEF_WAYS = 4.
- Sub-module my_rr_arbiter #(WAYS) is purely combinational: in_valid, ptr and mode in; one-hot grant and binary index out.
- The top module holds ptr, the output register and the data select (AND-OR of one-hot grant over ways).

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with all in_valid high → in_ready = 0, out_valid = 0, out_data = 0, out_sel = 0. Release → first grant is way 0.
- Fixed priority, WAYS = 4: in_valid = 4'b1010 held, out_ready = 1 → way 1 accepted every cycle and out_sel = 1 continuously; way 3 is never granted.
- Round-robin, WAYS = 4: all valid, data i = 16'hA000 + i, out_ready = 1 → out_data sequence A000, A001, A002, A003, A000 and so on, with a 1-cycle latency after the first acceptance.
- Backpressure: out_valid = 1 and out_ready low for 5 cycles → in_ready = 0, out_data/out_sel stable. Raise out_ready → drain and the next load happen on the same edge.
- Non-power-of-2 wrap, WAYS = 3, WIDTH = 8, round-robin, all valid → out_sel 0, 1, 2, 0; ptr never equals 3.
- Reset mid-stream: assert rst_n = 0 while out_valid = 1 → out_valid = 0 next edge, ptr = 0, and the held word is lost.
